instruction_fetch: RTL and testbench

//  Fetch stage directly upstream of the decode/control unit: owns the PC, issues

---
 rtl/instruction_fetch_pkg.sv | 21 ++
 rtl/instruction_fetch.sv | 89 ++++++++
 tb/tb_instruction_fetch.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the fetch stage: data width, reset defaults and the
// fetch FSM state encoding.
package instruction_fetch_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] INST_NOP         = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH_REQ  = 2'd0,
        FETCH_WAIT = 2'd1,
        FETCH_DROP = 2'd2,
        FETCH_ERR  = 2'd3
    } fetch_state_t;

    function automatic logic word_aligned(input logic [XLEN-1:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, keeps one instruction-memory read in flight and
// hands fetched words to decode through a single-entry valid/ready slot.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [XLEN-1:0] NOP_INST = INST_NOP
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            inst_valid,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    input  logic            dec_ready,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            fetch_misalign
);

    fetch_state_t    state;
    fetch_state_t    state_next;
    logic [XLEN-1:0] pc;
    logic            fill;
    logic            redirect_aligned;

    // A request may only go out when the slot is empty or draining this cycle,
    // so a returning response never finds the slot occupied.
    assign imem_req = !rst && (state == FETCH_REQ) && (!inst_valid || dec_ready)
                      && !redirect_valid;
    assign imem_addr        = pc;
    assign fill             = (state == FETCH_WAIT) && imem_rvalid && !redirect_valid;
    assign redirect_aligned = word_aligned(redirect_pc);

    // NOTE: state_next gets a default before any branch so no path leaves it
    // unassigned; that is what keeps this block free of inferred latches.
    always_comb begin
        state_next = state;
        if (redirect_valid) begin
            if (!redirect_aligned)
                state_next = FETCH_ERR;
            else if ((state == FETCH_WAIT || state == FETCH_DROP) && !imem_rvalid)
                state_next = FETCH_DROP;
            else
                state_next = FETCH_REQ;
        end else begin
            case (state)
                FETCH_REQ:  if (imem_req && imem_gnt) state_next = FETCH_WAIT;
                FETCH_WAIT: if (imem_rvalid) state_next = FETCH_REQ;
                FETCH_DROP: if (imem_rvalid) state_next = FETCH_REQ;
                default:    state_next = state;
            endcase
        end
    end

    // NOTE: every register here uses <= so all of them update from the values
    // seen before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= FETCH_REQ;
            pc             <= RESET_PC;
            inst_valid     <= 1'b0;
            inst           <= NOP_INST;
            inst_pc        <= '0;
            fetch_misalign <= 1'b0;
        end else begin
            state <= state_next;
            if (redirect_valid) begin
                pc             <= redirect_pc;
                inst_valid     <= 1'b0;
                inst           <= NOP_INST;
                fetch_misalign <= !redirect_aligned;
            end else if (fill) begin
                inst       <= imem_rdata;
                inst_pc    <= pc;
                inst_valid <= 1'b1;
                pc         <= pc + XLEN'(4);
            end else if (inst_valid && dec_ready) begin
                inst_valid <= 1'b0;
                inst       <= NOP_INST;
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios followed by
// randomized traffic, checked against a transaction-level fetch model.
module tb_instruction_fetch;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] BAD  = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        dec_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_misalign;

    instruction_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .dec_ready      (dec_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_misalign (fetch_misalign)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return (addr * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    // Memory-side and program-order model state.
    int          gnt_pct = 100;
    int          lat_min = 1;
    int          lat_max = 1;
    bit          data_bad = 1'b0;
    bit          outstanding;
    int          countdown;
    logic [31:0] out_addr;
    bit          out_stale;
    bit          out_bad;
    logic [31:0] fetch_pc;
    logic [31:0] exp_pc;
    bit          slot_full;
    logic [31:0] slot_inst;
    logic [31:0] slot_pc;
    bit          misalign_m;

    bit          last_req;
    bit          last_grant;
    bit          last_rvalid;
    logic [31:0] last_grant_addr;
    int          cyc = 0;
    int          first_req_cyc;
    int          first_valid_cyc;
    bit          seen_bad = 1'b0;
    logic [31:0] consumed_pcs[$];

    task automatic model_reset();
        outstanding = 1'b0;
        countdown   = 0;
        fetch_pc    = 32'h0;
        exp_pc      = 32'h0;
        slot_full   = 1'b0;
        slot_inst   = NOP;
        slot_pc     = 32'h0;
        misalign_m  = 1'b0;
        data_bad    = 1'b0;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        dec_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        #1;
        check("req_in_reset", imem_req, 1'b0);
        @(negedge clk);
        #1;
        check("rst_inst_valid", inst_valid, 1'b0);
        check("rst_inst", inst, NOP);
        check("rst_inst_pc", inst_pc, 32'h0);
        check("rst_misalign", fetch_misalign, 1'b0);
        check("rst_addr", imem_addr, 32'h0);
        model_reset();
    endtask

    // One clock cycle: drive inputs at the falling edge, compare against the
    // model, then advance the model to what the next rising edge must do.
    task automatic step(input bit rdy, input bit redir, input logic [31:0] tgt);
        bit          rv;
        bit          req_exp;
        bit          grant;
        bit          accepted;
        bit          was_full;
        @(negedge clk);
        cyc++;
        rst            = 1'b0;
        dec_ready      = rdy;
        redirect_valid = redir;
        redirect_pc    = tgt;
        imem_gnt       = ($urandom_range(99) < gnt_pct);
        rv             = outstanding && (countdown == 1);
        imem_rvalid    = rv;
        imem_rdata     = rv ? (out_bad ? BAD : mem_word(out_addr)) : $urandom();
        #1;
        req_exp = !outstanding && !misalign_m && (!slot_full || rdy) && !redir;
        check("imem_req", imem_req, req_exp);
        check("inst_valid", inst_valid, slot_full);
        if (slot_full) begin
            check("inst", inst, slot_inst);
            check("inst_pc", inst_pc, slot_pc);
        end else begin
            check("inst_nop", inst, NOP);
        end
        check("fetch_misalign", fetch_misalign, misalign_m);
        if (inst_valid && inst == BAD) seen_bad = 1'b1;
        if (imem_req && first_req_cyc < 0) first_req_cyc = cyc;
        if (inst_valid && first_valid_cyc < 0) first_valid_cyc = cyc;

        grant    = imem_req && imem_gnt;
        was_full = slot_full;
        if (grant) check("imem_addr", imem_addr, fetch_pc);

        // Decode consumes in program order: the old instruction even when a
        // redirect lands in the same cycle.
        if (was_full && rdy) begin
            check("consume_pc", inst_pc, exp_pc);
            check("consume_inst", inst, mem_word(exp_pc));
            consumed_pcs.push_back(inst_pc);
            exp_pc = exp_pc + 32'd4;
        end

        accepted = 1'b0;
        if (rv) begin
            outstanding = 1'b0;
            accepted    = !out_stale && !redir;
        end else if (outstanding) begin
            countdown--;
        end
        if (grant) begin
            outstanding = 1'b1;
            out_addr    = fetch_pc;
            out_stale   = 1'b0;
            out_bad     = data_bad;
            data_bad    = 1'b0;
            countdown   = $urandom_range(lat_max, lat_min);
        end

        if (redir) begin
            slot_full  = 1'b0;
            if (outstanding) out_stale = 1'b1;
            fetch_pc   = tgt;
            exp_pc     = tgt;
            misalign_m = (tgt[1:0] != 2'b00);
        end else if (accepted) begin
            slot_full = 1'b1;
            slot_inst = out_bad ? BAD : mem_word(out_addr);
            slot_pc   = out_addr;
            fetch_pc  = fetch_pc + 32'd4;
        end else if (was_full && rdy) begin
            slot_full = 1'b0;
        end

        last_req        = imem_req;
        last_grant      = grant;
        last_rvalid     = rv;
        last_grant_addr = imem_addr;
    endtask

    task automatic wait_grant(input string tag);
        last_grant = 1'b0;
        for (int i = 0; i < 40 && !last_grant; i++) step(1'b1, 1'b0, 32'h0);
        if (!last_grant) check(tag, 1'b0, 1'b1);
    endtask

    task automatic drain(input string tag);
        int saved = gnt_pct;
        gnt_pct = 0;
        for (int i = 0; i < 40 && outstanding; i++) step(1'b1, 1'b0, 32'h0);
        if (outstanding) check(tag, 1'b1, 1'b0);
        gnt_pct = saved;
    endtask

    initial begin
        first_req_cyc   = -1;
        first_valid_cyc = -1;
        model_reset();
        reset_dut();

        // Streaming at minimum latency; first valid two cycles after first request.
        gnt_pct = 100; lat_min = 1; lat_max = 1;
        repeat (8) step(1'b1, 1'b0, 32'h0);
        check("first_valid_latency", 32'(first_valid_cyc - first_req_cyc), 32'd2);

        // Decode stall for five cycles, then release.
        for (int i = 0; i < 10 && !slot_full; i++) step(1'b1, 1'b0, 32'h0);
        drain("stall_drain_timeout");
        repeat (5) step(1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        check("release_req", last_req, 1'b1);

        // Redirect while waiting; the stale DEADBEEF response must be dropped.
        drain("pre_wait_drain_timeout");
        lat_min = 3; lat_max = 3;
        data_bad = 1'b1;
        wait_grant("wait_grant_timeout");
        step(1'b1, 1'b1, 32'h0000_0100);
        lat_min = 1; lat_max = 1;
        wait_grant("after_redirect_grant_timeout");
        check("redirect_addr", last_grant_addr, 32'h0000_0100);

        // Misaligned target parks the fetcher until an aligned redirect.
        drain("pre_misalign_drain_timeout");
        step(1'b1, 1'b1, 32'h0000_0102);
        repeat (3) step(1'b1, 1'b0, 32'h0);
        check("err_flag", fetch_misalign, 1'b1);
        check("err_no_req", last_req, 1'b0);
        step(1'b1, 1'b1, 32'h0000_0200);
        wait_grant("after_err_grant_timeout");
        check("err_exit_flag", fetch_misalign, 1'b0);
        check("err_exit_addr", last_grant_addr, 32'h0000_0200);

        // Response and redirect in the same cycle.
        drain("pre_coincide_drain_timeout");
        lat_min = 2; lat_max = 2;
        wait_grant("coincide_grant_timeout");
        step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'h0000_0300);
        check("coincide_rvalid", last_rvalid, 1'b1);
        lat_min = 1; lat_max = 1;
        step(1'b1, 1'b0, 32'h0);
        check("coincide_next_req", last_grant, 1'b1);
        check("coincide_addr", last_grant_addr, 32'h0000_0300);

        // PC wraps from the top of the address space.
        drain("pre_wrap_drain_timeout");
        step(1'b1, 1'b1, 32'hFFFF_FFFC);
        consumed_pcs.delete();
        repeat (8) step(1'b1, 1'b0, 32'h0);
        if (consumed_pcs.size() >= 2) begin
            check("wrap_pc0", consumed_pcs[0], 32'hFFFF_FFFC);
            check("wrap_pc1", consumed_pcs[1], 32'h0000_0000);
        end else begin
            check("wrap_count", 32'(consumed_pcs.size()), 32'd2);
        end

        // Randomized traffic with one reset in the middle.
        gnt_pct = 70; lat_min = 1; lat_max = 4;
        for (int i = 0; i < 2000; i++) begin
            bit          rdy;
            bit          redir;
            logic [31:0] tgt;
            if (i == 1000) reset_dut();
            rdy   = ($urandom_range(99) < 75);
            redir = ($urandom_range(99) < 4);
            tgt   = $urandom() & 32'h0000_FFFC;
            case ($urandom_range(9))
                0: tgt = 32'hFFFF_FFFC;
                1, 2: if (!outstanding) tgt = tgt | 32'(1 + $urandom_range(2));
                default: ;
            endcase
            step(rdy, redir, tgt);
        end
        drain("final_drain_timeout");
        check("never_bad_valid", seen_bad, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
